// File: rtl/pc_trace_monitor.sv
// pc_trace_monitor: records every change of the processor PC together with a
// 16-bit cycle stamp into a show-ahead FIFO read through a ready/valid port.
// Also flags long fetch stalls and counts entries dropped while the FIFO is full.
module pc_trace_monitor #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned STALL_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         pc_in,
    input  logic                     clear,
    input  logic                     trace_ready,
    output logic                     trace_valid,
    output logic [WIDTH-1:0]         trace_pc,
    output logic [15:0]              trace_cycle,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic                     stall
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

    // Entry storage; only the occupied slots are ever observed, so no reset.
    logic [WIDTH-1:0] pc_mem_q  [DEPTH];
    logic [15:0]      cyc_mem_q [DEPTH];

    logic             primed_q,   primed_d;
    logic [WIDTH-1:0] prev_pc_q,  prev_pc_d;
    logic [15:0]      cyc_q,      cyc_d;
    logic [SW-1:0]    same_cnt_q, same_cnt_d;
    logic             stall_q,    stall_d;
    logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]    count_q,    count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic change, push_req, pop, full, push_ok, drop, we;

    // Capture, FIFO bookkeeping and stall tracking for the coming edge.
    always_comb begin
        change   = (pc_in != prev_pc_q);
        push_req = !primed_q || change;
        pop      = (count_q != '0) && trace_ready;
        full     = (count_q == FULL_CNT);
        // A pop on the same edge frees the slot the new entry needs.
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;

        primed_d   = 1'b1;
        prev_pc_d  = pc_in;
        cyc_d      = cyc_q + 16'd1;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        we         = 1'b0;

        if (change)
            same_cnt_d = '0;
        else if (same_cnt_q == STALL_MAX)
            same_cnt_d = same_cnt_q;
        else
            same_cnt_d = same_cnt_q + 1'b1;
        stall_d = primed_d && (same_cnt_d >= STALL_MAX);

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            we = push_ok;
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            primed_q   <= 1'b0;
            prev_pc_q  <= '0;
            cyc_q      <= '0;
            same_cnt_q <= '0;
            stall_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            primed_q   <= primed_d;
            prev_pc_q  <= prev_pc_d;
            cyc_q      <= cyc_d;
            same_cnt_q <= same_cnt_d;
            stall_q    <= stall_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry write port, stamped with the cycle of the capturing edge.
    always_ff @(posedge clk) begin
        if (we) begin
            pc_mem_q[wr_ptr_q]  <= pc_in;
            cyc_mem_q[wr_ptr_q] <= cyc_q;
        end
    end

    // Head entry is forced to zero while empty so reset/clear show all-zero outputs.
    assign trace_valid = (count_q != '0);
    assign trace_pc    = trace_valid ? pc_mem_q[rd_ptr_q]  : '0;
    assign trace_cycle = trace_valid ? cyc_mem_q[rd_ptr_q] : '0;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_cnt_q;
    assign stall       = stall_q;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Directed bench for pc_trace_monitor with a queue-based scoreboard of trace entries.
module tb_pc_trace_monitor;

    localparam int WIDTH = 64;
    localparam int DEPTH = 16;
    localparam int SL    = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [WIDTH-1:0]  pc_in;
    logic              clear;
    logic              trace_ready;
    logic              trace_valid;
    logic [WIDTH-1:0]  trace_pc;
    logic [15:0]       trace_cycle;
    logic [4:0]        count;
    logic              overflow;
    logic [7:0]        drop_count;
    logic              stall;

    pc_trace_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_LIMIT(SL)) dut (
        .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .clear(clear),
        .trace_ready(trace_ready), .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_cycle(trace_cycle), .count(count), .overflow(overflow),
        .drop_count(drop_count), .stall(stall)
    );

    always #5 clk = ~clk;

    // Scoreboard entries are {pc, stamp}; model state mirrors the observable behaviour.
    logic [79:0] exp_q[$];
    logic [15:0] m_cyc;
    logic        m_primed;
    logic [63:0] m_prev;
    int          m_same;
    logic        m_ovf;
    int          m_drop;
    logic        m_stall;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cyc = '0; m_primed = 1'b0; m_prev = '0; m_same = 0;
        m_ovf = 1'b0; m_drop = 0; m_stall = 1'b0;
    endtask

    task automatic check_all();
        logic [79:0] head;
        chk("valid",    80'(trace_valid), 80'(exp_q.size() != 0));
        chk("count",    80'(count),       80'(exp_q.size()));
        chk("overflow", 80'(overflow),    80'(m_ovf));
        chk("drops",    80'(drop_count),  80'(m_drop));
        chk("stall",    80'(stall),       80'(m_stall));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            chk("head_pc",    80'(trace_pc),    80'(head[79:16]));
            chk("head_cycle", 80'(trace_cycle), 80'(head[15:0]));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 80'(trace_valid), 80'(0));
        chk({tag, "_pc"},    80'(trace_pc),    80'(0));
        chk({tag, "_cycle"}, 80'(trace_cycle), 80'(0));
        chk({tag, "_count"}, 80'(count),       80'(0));
        chk({tag, "_ovf"},   80'(overflow),    80'(0));
        chk({tag, "_drops"}, 80'(drop_count),  80'(0));
        chk({tag, "_stall"}, 80'(stall),       80'(0));
    endtask

    // Drive one edge worth of inputs, advance the model, then check after the edge.
    task automatic step(input logic [63:0] pc, input logic rdy, input logic clr);
        bit push, pop;
        pc_in = pc; trace_ready = rdy; clear = clr;
        pop  = (exp_q.size() != 0) && rdy;
        push = !m_primed || (pc != m_prev);
        if (clr) begin
            exp_q.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({pc, m_cyc});
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
        if (pc != m_prev) m_same = 0;
        else if (m_same < SL) m_same++;
        m_stall  = (m_same >= SL);
        m_prev   = pc;
        m_primed = 1'b1;
        m_cyc    = m_cyc + 16'd1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [15:0] stamp;
        reset_n = 1'b0; clear = 1'b0; trace_ready = 1'b0; pc_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;

        // Initial capture and stepping
        step(64'h0, 1'b1, 1'b0);
        chk("first_cycle", 80'(trace_cycle), 80'(0));
        step(64'h4, 1'b1, 1'b0);
        step(64'h8, 1'b1, 1'b0);
        step(64'hC, 1'b1, 1'b0);
        chk("step_pc", 80'(trace_pc), 80'(64'hC));
        chk("step_cycle", 80'(trace_cycle), 80'(3));

        // Repeated PC suppression and stall
        step(64'h40, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(64'h40, 1'b1, 1'b0);
            if (i == 7) chk("stall_pre", 80'(stall), 80'(0));
            if (i == 8) chk("stall_rise", 80'(stall), 80'(1));
        end
        step(64'h44, 1'b1, 1'b0);
        chk("stall_fall", 80'(stall), 80'(0));
        step(64'h44, 1'b1, 1'b0);

        // Full and overflow
        for (int i = 0; i < 20; i++) step(64'h1000 + 64'(i * 4), 1'b0, 1'b0);
        chk("full_count", 80'(count), 80'(16));
        chk("full_ovf", 80'(overflow), 80'(1));
        chk("full_drops", 80'(drop_count), 80'(4));
        for (int i = 0; i < 16; i++) step(64'h104C, 1'b1, 1'b0);
        chk("drained", 80'(count), 80'(0));
        for (int i = 0; i < 16; i++) step(64'h2000 + 64'(i * 4), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(64'h3000 + 64'(i * 4), 1'b1, 1'b0);
        chk("pushpop_full_count", 80'(count), 80'(16));
        chk("pushpop_full_drops", 80'(drop_count), 80'(4));

        // Clear with 5 entries held and overflow set
        for (int i = 0; i < 11; i++) step(64'h3010, 1'b1, 1'b0);
        chk("pre_clear_count", 80'(count), 80'(5));
        step(64'h3010, 1'b0, 1'b1);
        chk("clr_count", 80'(count), 80'(0));
        chk("clr_valid", 80'(trace_valid), 80'(0));
        chk("clr_ovf", 80'(overflow), 80'(0));
        chk("clr_drops", 80'(drop_count), 80'(0));
        stamp = m_cyc;
        step(64'h5000, 1'b0, 1'b0);
        chk("post_clr_stamp", 80'(trace_cycle), 80'(stamp));
        step(64'h5004, 1'b0, 1'b0);
        step(64'h5008, 1'b0, 1'b0);
        chk("pre_rst_count", 80'(count), 80'(3));

        // Asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_zero("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step(64'h77, 1'b0, 1'b0);
        chk("rst_first_cycle", 80'(trace_cycle), 80'(0));
        chk("rst_first_pc", 80'(trace_pc), 80'(64'h77));

        // Cycle stamp wrap
        for (int i = 1; i <= 65534; i++) step(64'h77, 1'b1, 1'b0);
        step(64'h78, 1'b1, 1'b0);
        chk("wrap_ffff", 80'(trace_cycle), 80'(16'hFFFF));
        step(64'h79, 1'b1, 1'b0);
        chk("wrap_zero", 80'(trace_cycle), 80'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
